apb_reg_slave: RTL and testbench

- APB4 completer (slave) terminating the bus driven by the team's APB master interface.
- Hosts a parameterised bank of 32-bit control/status registers, with byte-strobe writes and programmable wait states.
- Reports errors on PSLVERR: bad address, read-only write, unprivileged write.
- Exports register contents and per-register write/read pulses to the surrounding IP. This is the generic back end for generated register blocks.

---
 rtl/apb_reg_pkg.sv | 41 ++++
 rtl/apb_reg_cell.sv | 33 +++
 rtl/apb_reg_slave.sv | 168 ++++++++++++++++
 tb/tb_apb_reg_slave.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register slave and its register cells.
package apb_reg_pkg;

  localparam int APB_DW = 32;
  localparam int APB_SW = 4;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO,
    ERR_PROT
  } apb_err_t;

  // Collapse the individual decode faults into one cause, most basic fault first.
  function automatic apb_err_t classify_err(input logic align_bad,
                                            input logic range_bad,
                                            input logic ro_bad,
                                            input logic prot_bad);
    apb_err_t cause;
    cause = ERR_NONE;
    if (align_bad) begin
      cause = ERR_ALIGN;
    end else if (range_bad) begin
      cause = ERR_RANGE;
    end else if (ro_bad) begin
      cause = ERR_RO;
    end else if (prot_bad) begin
      cause = ERR_PROT;
    end
    return cause;
  endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// One 32-bit read/write register with a reset value and per-byte write enables.
module apb_reg_cell
  import apb_reg_pkg::*;
#(
  parameter logic [APB_DW-1:0] RST_VAL = '0
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              we,
  input  logic [APB_SW-1:0] strb,
  input  logic [APB_DW-1:0] wdata,
  output logic [APB_DW-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < APB_SW; gi++) begin : g_byte
      logic [7:0] byte_reg;

      // Each byte lane updates only when the write is accepted and its strobe is set.
      always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
          byte_reg <= RST_VAL[gi*8 +: 8];
        end else if (we && strb[gi]) begin
          byte_reg <= wdata[gi*8 +: 8];
        end
      end

      assign q[gi*8 +: 8] = byte_reg;
    end
  endgenerate

endmodule

// File: rtl/apb_reg_slave.sv
// APB4 completer hosting a bank of 32-bit registers with strobed writes,
// programmable wait states and PSLVERR on bad address, RO write or unprivileged write.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int                           NUM_REGS    = 8,
  parameter int                           ADDR_W      = 12,
  parameter int                           WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]          RO_MASK     = '0,
  parameter logic [NUM_REGS*APB_DW-1:0]   RST_VAL     = '0,
  parameter bit                           PROT_EN     = 1'b0
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [31:0]                  paddr,
  input  logic [APB_DW-1:0]            pwdata,
  input  logic [APB_SW-1:0]            pstrb,
  input  logic [2:0]                   pprot,
  output logic [APB_DW-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*APB_DW-1:0]   reg_q,
  input  logic [NUM_REGS*APB_DW-1:0]   hw_status,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic [NUM_REGS-1:0]          rd_pulse
);

  localparam int                IDX_W     = ADDR_W - 2;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  apb_state_t          state_reg, state_next;
  logic [WAIT_W-1:0]   cnt_reg, cnt_next;
  logic                capture;

  logic [NUM_REGS-1:0] sel_reg;
  apb_err_t            err_reg;
  logic                write_reg;

  logic [IDX_W-1:0]    idx_live;
  logic [NUM_REGS-1:0] sel_live;
  apb_err_t            err_live;

  logic                        xfer_ok;
  logic [NUM_REGS*APB_DW-1:0]  rd_view;
  logic [APB_DW-1:0]           rd_word;

  // Address bits above the decoded window, the upper protection bits and the
  // status slices of RW registers have no function here.
  logic unused_inputs;
  assign unused_inputs = ^{paddr[31:ADDR_W], pprot[2:1], hw_status};

  // Decode the live bus in the setup cycle; the result is frozen for the access phase.
  assign idx_live = paddr[ADDR_W-1:2];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign sel_live[gi] = (idx_live == IDX_W'(gi));
    end
  endgenerate

  assign err_live = classify_err(|paddr[1:0],
                                 ~|sel_live,
                                 pwrite & (|(sel_live & RO_MASK)),
                                 PROT_EN & pwrite & ~pprot[0]);

  // State and wait counter; reset aborts any transfer in flight.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Hold the setup-cycle decode so address/control changes during ACCESS are ignored.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      sel_reg   <= '0;
      err_reg   <= ERR_NONE;
      write_reg <= 1'b0;
    end else if (capture) begin
      sel_reg   <= sel_live;
      err_reg   <= err_live;
      write_reg <= pwrite;
    end
  end

  // Next-state and handshake: SETUP is the first access cycle after a captured
  // setup; ACCESS covers the remaining wait-state cycles. PREADY rises only
  // when the counter has drained and the bus is still in its access phase.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    pready     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (psel && !penable) begin
          capture    = 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = SETUP;
        end
      end
      SETUP, ACCESS: begin
        if (!(psel && penable)) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          pready     = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next   = cnt_reg - 1'b1;
          state_next = ACCESS;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign xfer_ok  = pready && (err_reg == ERR_NONE);
  assign pslverr  = pready && (err_reg != ERR_NONE);
  assign wr_pulse = {NUM_REGS{xfer_ok &  write_reg}} & sel_reg;
  assign rd_pulse = {NUM_REGS{xfer_ok & ~write_reg}} & sel_reg;

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
        assign reg_q[gi*APB_DW +: APB_DW]   = '0;
        assign rd_view[gi*APB_DW +: APB_DW] = hw_status[gi*APB_DW +: APB_DW];
      end else begin : g_rw
        logic [APB_DW-1:0] cell_q;

        apb_reg_cell #(
          .RST_VAL(RST_VAL[gi*APB_DW +: APB_DW])
        ) u_cell (
          .pclk    (pclk),
          .preset_n(preset_n),
          .we      (wr_pulse[gi]),
          .strb    (pstrb),
          .wdata   (pwdata),
          .q       (cell_q)
        );

        assign reg_q[gi*APB_DW +: APB_DW]   = cell_q;
        assign rd_view[gi*APB_DW +: APB_DW] = cell_q;
      end
    end
  endgenerate

  // Read mux over the one-hot select; PRDATA stays zero outside a good read completion.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_reg[i]) begin
        rd_word = rd_word | rd_view[i*APB_DW +: APB_DW];
      end
    end
    prdata = (xfer_ok && !write_reg) ? rd_word : '0;
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: two slave instances (zero-wait with RO/PROT features, and
// three-wait-state plain bank) on a shared APB bus with separate selects.
module tb_apb_reg_slave;

  localparam int N = 8;
  localparam logic [N*32-1:0] RST0 = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                      32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
  localparam logic [N*32-1:0] RST3 = {224'h0, 32'hCAFE_F00D};

  logic            pclk;
  logic            preset_n;
  logic            psel0, psel3;
  logic            penable, pwrite;
  logic [31:0]     paddr, pwdata;
  logic [3:0]      pstrb;
  logic [2:0]      pprot;

  logic [31:0]     prdata0, prdata3;
  logic            pready0, pready3, pslverr0, pslverr3;
  logic [N*32-1:0] reg_q0, reg_q3, hw_status0, hw_status3;
  logic [N-1:0]    wr_pulse0, wr_pulse3, rd_pulse0, rd_pulse3;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0]  r_data;
  logic         r_err;
  logic [N-1:0] r_wr, r_rd;
  int           r_cycles, r_waits;
  logic         seen;

  apb_reg_slave #(
    .NUM_REGS(N), .ADDR_W(12), .WAIT_CYCLES(0), .RO_MASK(8'h04), .RST_VAL(RST0), .PROT_EN(1'b1)
  ) dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .reg_q(reg_q0),
    .hw_status(hw_status0), .wr_pulse(wr_pulse0), .rd_pulse(rd_pulse0)
  );

  apb_reg_slave #(
    .NUM_REGS(N), .ADDR_W(12), .WAIT_CYCLES(3), .RO_MASK(8'h00), .RST_VAL(RST3), .PROT_EN(1'b0)
  ) dut3 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3), .reg_q(reg_q3),
    .hw_status(hw_status3), .wr_pulse(wr_pulse3), .rd_pulse(rd_pulse3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full APB transfer to instance d (0 or 3); optionally moves paddr during wait states.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot, input bit glitch);
    logic done;
    int   budget;
    @(posedge pclk); #1;
    psel0 = (d == 0); psel3 = (d == 3); penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
    r_cycles = 1; r_waits = 0; r_data = '0; r_err = 1'b0; r_wr = '0; r_rd = '0;
    done = 1'b0; budget = 0;
    @(posedge pclk); #1;
    penable = 1'b1;
    while (!done && budget < 32) begin
      r_cycles++; budget++;
      @(negedge pclk);
      if ((d == 0) ? pready0 : pready3) begin
        done   = 1'b1;
        r_data = (d == 0) ? prdata0 : prdata3;
        r_err  = (d == 0) ? pslverr0 : pslverr3;
        r_wr   = (d == 0) ? wr_pulse0 : wr_pulse3;
        r_rd   = (d == 0) ? rd_pulse0 : rd_pulse3;
      end else begin
        r_waits++;
        @(posedge pclk); #1;
        if (glitch) paddr = addr + 32'h4;
      end
    end
    check("pready_within_budget", {31'd0, done}, 32'd1);
    @(posedge pclk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    $display("xfer dut%0d %s addr=%h data=%h strb=%h prot=%0d -> prdata=%h err=%0d cycles=%0d",
             d, wr ? "WR" : "RD", addr, data, strb, prot, r_data, r_err, r_cycles);
  endtask

  initial begin
    preset_n = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
    hw_status0 = '0; hw_status0[2*32 +: 32] = 32'hDEAD_BEEF;
    hw_status3 = '0;

    // Reset state
    repeat (2) @(negedge pclk);
    check("rst_pready0", {31'd0, pready0}, 32'd0);
    check("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
    check("rst_prdata0", prdata0, 32'd0);
    check("rst_wr_pulse0", {24'd0, wr_pulse0}, 32'd0);
    check("rst_rd_pulse0", {24'd0, rd_pulse0}, 32'd0);
    check("rst_reg_q0_1", reg_q0[1*32 +: 32], 32'h1111_0001);
    check("rst_reg_q0_2_ro", reg_q0[2*32 +: 32], 32'h0);
    check("rst_pready3", {31'd0, pready3}, 32'd0);
    @(posedge pclk); #1;
    preset_n = 1'b1;

    // Full write, zero wait states
    xfer(0, 1'b1, 32'h004, 32'hA5A5_1234, 4'hF, 3'b001, 1'b0);
    check("wr_cycles", r_cycles, 32'd2);
    check("wr_pslverr", {31'd0, r_err}, 32'd0);
    check("wr_pulse", {24'd0, r_wr}, 32'h02);
    check("wr_pulse_gone", {24'd0, wr_pulse0}, 32'd0);
    check("wr_reg_q1", reg_q0[1*32 +: 32], 32'hA5A5_1234);

    xfer(0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b001, 1'b0);
    check("rd_back", r_data, 32'hA5A5_1234);
    check("rd_back_err", {31'd0, r_err}, 32'd0);
    check("rd_back_pulse", {24'd0, r_rd}, 32'h02);
    check("rd_prdata_idle", prdata0, 32'd0);

    // Partial byte write
    xfer(0, 1'b1, 32'h004, 32'h0000_00FF, 4'b0001, 3'b001, 1'b0);
    check("partial_reg_q1", reg_q0[1*32 +: 32], 32'hA5A5_12FF);

    // Out of range and misaligned reads
    xfer(0, 1'b0, 32'h040, 32'h0, 4'h0, 3'b001, 1'b0);
    check("range_err", {31'd0, r_err}, 32'd1);
    check("range_prdata", r_data, 32'd0);
    check("range_rd_pulse", {24'd0, r_rd}, 32'd0);
    xfer(0, 1'b0, 32'h002, 32'h0, 4'h0, 3'b001, 1'b0);
    check("align_err", {31'd0, r_err}, 32'd1);
    check("align_prdata", r_data, 32'd0);
    check("align_rd_pulse", {24'd0, r_rd}, 32'd0);

    // Read-only register
    xfer(0, 1'b1, 32'h008, 32'h1234_5678, 4'hF, 3'b001, 1'b0);
    check("ro_wr_err", {31'd0, r_err}, 32'd1);
    check("ro_wr_pulse", {24'd0, r_wr}, 32'd0);
    check("ro_reg_q2", reg_q0[2*32 +: 32], 32'd0);
    xfer(0, 1'b0, 32'h008, 32'h0, 4'h0, 3'b001, 1'b0);
    check("ro_rd_data", r_data, 32'hDEAD_BEEF);
    check("ro_rd_pulse", {24'd0, r_rd}, 32'h04);

    // Privilege check
    xfer(0, 1'b1, 32'h00C, 32'h1234_5678, 4'hF, 3'b000, 1'b0);
    check("prot_err", {31'd0, r_err}, 32'd1);
    check("prot_reg_kept", reg_q0[3*32 +: 32], 32'h3333_0003);
    xfer(0, 1'b1, 32'h00C, 32'h1234_5678, 4'hF, 3'b001, 1'b0);
    check("priv_ok", {31'd0, r_err}, 32'd0);
    check("priv_reg_q3", reg_q0[3*32 +: 32], 32'h1234_5678);

    // Zero strobes: OKAY, pulse, no change
    xfer(0, 1'b1, 32'h010, 32'hFFFF_FFFF, 4'h0, 3'b001, 1'b0);
    check("strb0_err", {31'd0, r_err}, 32'd0);
    check("strb0_pulse", {24'd0, r_wr}, 32'h10);
    check("strb0_reg_q4", reg_q0[4*32 +: 32], 32'h4444_0004);

    // penable without a prior setup is ignored
    @(posedge pclk); #1;
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h004; pwdata = 32'h0; pstrb = 4'hF;
    seen = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      seen = seen | pready0 | (|wr_pulse0);
    end
    @(posedge pclk); #1;
    psel0 = 1'b0; penable = 1'b0;
    check("noset_no_ready", {31'd0, seen}, 32'd0);
    check("noset_reg_q1", reg_q0[1*32 +: 32], 32'hA5A5_12FF);

    // Wait states: read of reset value
    xfer(3, 1'b0, 32'h000, 32'h0, 4'h0, 3'b001, 1'b0);
    check("wait_cycles", r_cycles, 32'd5);
    check("wait_low_cycles", r_waits, 32'd3);
    check("wait_prdata", r_data, 32'hCAFE_F00D);
    check("wait_rd_pulse", {24'd0, r_rd}, 32'h01);

    // psel dropped mid-ACCESS: no write, no pulse
    @(posedge pclk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'h9999_9999; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel3 = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      seen = seen | pready3 | (|wr_pulse3);
    end
    check("abort_no_pulse", {31'd0, seen}, 32'd0);
    check("abort_reg_q4", reg_q3[4*32 +: 32], 32'd0);

    // Address changed during wait states is ignored
    xfer(3, 1'b1, 32'h004, 32'h55AA_55AA, 4'hF, 3'b001, 1'b1);
    check("glitch_cycles", r_cycles, 32'd5);
    check("glitch_pulse", {24'd0, r_wr}, 32'h02);
    check("glitch_reg_q1", reg_q3[1*32 +: 32], 32'h55AA_55AA);
    check("glitch_reg_q2", reg_q3[2*32 +: 32], 32'd0);

    // Reset during a wait-state write
    @(posedge pclk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00C; pwdata = 32'h1111_2222; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #2;
    preset_n = 1'b0;
    #1;
    check("rstmid_pready", {31'd0, pready3}, 32'd0);
    check("rstmid_reg_q3", reg_q3[3*32 +: 32], 32'd0);
    check("rstmid_reg_q3_1", reg_q3[1*32 +: 32], 32'd0);
    check("rstmid_dut0_reg_q1", reg_q0[1*32 +: 32], 32'h1111_0001);
    @(posedge pclk); #1;
    psel3 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    @(negedge pclk);
    check("rstmid_after_reg_q3", reg_q3[3*32 +: 32], 32'd0);
    xfer(3, 1'b1, 32'h00C, 32'h0BAD_F00D, 4'hF, 3'b001, 1'b0);
    check("restart_err", {31'd0, r_err}, 32'd0);
    check("restart_cycles", r_cycles, 32'd5);
    check("restart_reg_q3", reg_q3[3*32 +: 32], 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
